// File: rtl/keypad_entry_ctrl.sv
// keypad_entry_ctrl: 4x3 matrix keypad scanner, full-scan debouncer and decimal digit entry
// with a valid/ready command output. Define ENTRY_TIMEOUT_EN to clear stale partial entries.
module keypad_entry_ctrl #(
    parameter int SCAN_DIV    = 1000,
    parameter int DEBOUNCE    = 4,
    parameter int NDIGITS     = 2,
    parameter int VAL_W       = 7,
    parameter int TIMEOUT_CYC = 100000000
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [2:0]                   key_col,
    output logic [3:0]                   key_row,
    output logic                         key_event,
    output logic [3:0]                   key_code,
    output logic [$clog2(NDIGITS+1)-1:0] digit_count,
    output logic [VAL_W-1:0]             cmd_value,
    output logic                         cmd_valid,
    input  logic                         cmd_ready
);
    localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int BW = $clog2(DEBOUNCE + 1);
    localparam int CW = $clog2(NDIGITS + 1);
    localparam int AW = VAL_W + 4;

    localparam logic [3:0] NO_KEY   = 4'hF;
    localparam logic [3:0] KEY_STAR = 4'hA;
    localparam logic [3:0] KEY_HASH = 4'hB;

    localparam logic [1:0] DB_IDLE    = 2'd0;
    localparam logic [1:0] DB_CONFIRM = 2'd1;
    localparam logic [1:0] DB_HELD    = 2'd2;
    localparam logic [1:0] DB_RELEASE = 2'd3;

    localparam logic [0:0] EN_ENTRY  = 1'b0;
    localparam logic [0:0] EN_OUTPUT = 1'b1;

    logic [DW-1:0]    div_cnt_r;
    logic [3:0]       key_row_r;
    logic             scan_found_r, scan_ghost_r;
    logic [3:0]       scan_key_r;
    logic [1:0]       db_state_r;
    logic [BW-1:0]    db_cnt_r;
    logic [3:0]       db_cand_r;
    logic             key_event_r;
    logic [3:0]       key_code_r;
    logic [0:0]       en_state_r;
    logic [VAL_W-1:0] acc_r;
    logic [CW-1:0]    digit_count_r;
    logic [VAL_W-1:0] cmd_value_r;
    logic             cmd_valid_r;

    logic             sample_s, scan_end_s;
    logic             row_any_s, row_one_s;
    logic [3:0]       col_off_s, row_code_s;
    logic             cur_found_s, cur_ghost_s;
    logic [3:0]       cur_key_s, scan_result_s;
    logic             digit_s, timeout_s;
    logic [AW-1:0]    acc_calc_s;

    // Decode the sampled columns of the active row into a key code
    always_comb begin
        row_any_s = |key_col;
        row_one_s = (key_col == 3'b100) || (key_col == 3'b010) || (key_col == 3'b001);
        case (key_col)
            3'b010:  col_off_s = 4'd1;
            3'b001:  col_off_s = 4'd2;
            default: col_off_s = 4'd0;
        endcase
        case (key_row_r)
            4'b1000: row_code_s = 4'd1 + col_off_s;
            4'b0100: row_code_s = 4'd4 + col_off_s;
            4'b0010: row_code_s = 4'd7 + col_off_s;
            4'b0001: begin
                case (key_col)
                    3'b100:  row_code_s = KEY_STAR;
                    3'b010:  row_code_s = 4'd0;
                    3'b001:  row_code_s = KEY_HASH;
                    default: row_code_s = NO_KEY;
                endcase
            end
            default: row_code_s = NO_KEY;
        endcase
    end

    // Fold this row into the running scan result; a second hit anywhere is a ghost
    always_comb begin
        sample_s    = (div_cnt_r == DW'(SCAN_DIV - 1));
        scan_end_s  = sample_s && key_row_r[0];
        cur_ghost_s = scan_ghost_r || (row_any_s && (scan_found_r || !row_one_s));
        cur_found_s = scan_found_r || row_any_s;
        if (row_any_s) begin
            cur_key_s = row_code_s;
        end else begin
            cur_key_s = scan_key_r;
        end
        if (cur_ghost_s || !cur_found_s) begin
            scan_result_s = NO_KEY;
        end else begin
            scan_result_s = cur_key_s;
        end
    end

    // Row dwell counter, row rotation and per-scan accumulation
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_cnt_r    <= {DW{1'b0}};
            key_row_r    <= 4'b1000;
            scan_found_r <= 1'b0;
            scan_ghost_r <= 1'b0;
            scan_key_r   <= NO_KEY;
        end else if (sample_s) begin
            div_cnt_r <= {DW{1'b0}};
            key_row_r <= {key_row_r[0], key_row_r[3:1]};
            if (scan_end_s) begin
                scan_found_r <= 1'b0;
                scan_ghost_r <= 1'b0;
                scan_key_r   <= NO_KEY;
            end else begin
                scan_found_r <= cur_found_s;
                scan_ghost_r <= cur_ghost_s;
                scan_key_r   <= cur_key_s;
            end
        end else begin
            div_cnt_r <= div_cnt_r + DW'(1);
        end
    end

    // Debounce across full scans; one event per accepted press, no auto-repeat
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            db_state_r  <= DB_IDLE;
            db_cnt_r    <= {BW{1'b0}};
            db_cand_r   <= NO_KEY;
            key_event_r <= 1'b0;
            key_code_r  <= NO_KEY;
        end else begin
            key_event_r <= 1'b0;
            if (scan_end_s) begin
                case (db_state_r)
                    DB_IDLE: begin
                        if (scan_result_s != NO_KEY) begin
                            db_cand_r <= scan_result_s;
                            if (DEBOUNCE == 1) begin
                                key_event_r <= 1'b1;
                                key_code_r  <= scan_result_s;
                                db_state_r  <= DB_HELD;
                            end else begin
                                db_cnt_r   <= BW'(1);
                                db_state_r <= DB_CONFIRM;
                            end
                        end
                    end
                    DB_CONFIRM: begin
                        if (scan_result_s == db_cand_r) begin
                            if (db_cnt_r == BW'(DEBOUNCE - 1)) begin
                                key_event_r <= 1'b1;
                                key_code_r  <= db_cand_r;
                                db_state_r  <= DB_HELD;
                            end else begin
                                db_cnt_r <= db_cnt_r + BW'(1);
                            end
                        end else begin
                            db_state_r <= DB_IDLE;
                        end
                    end
                    DB_HELD: begin
                        if (scan_result_s == NO_KEY) begin
                            if (DEBOUNCE == 1) begin
                                db_state_r <= DB_IDLE;
                            end else begin
                                db_cnt_r   <= BW'(1);
                                db_state_r <= DB_RELEASE;
                            end
                        end
                    end
                    DB_RELEASE: begin
                        if (scan_result_s == NO_KEY) begin
                            if (db_cnt_r == BW'(DEBOUNCE - 1)) begin
                                db_state_r <= DB_IDLE;
                            end else begin
                                db_cnt_r <= db_cnt_r + BW'(1);
                            end
                        end else begin
                            db_state_r <= DB_HELD;
                        end
                    end
                    default: db_state_r <= DB_IDLE;
                endcase
            end
        end
    end

`ifdef ENTRY_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] idle_cnt_r;

    // Cycles since the last debounced press, saturating at the limit
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idle_cnt_r <= {TW{1'b0}};
        end else if (key_event_r) begin
            idle_cnt_r <= {TW{1'b0}};
        end else if (idle_cnt_r != TW'(TIMEOUT_CYC)) begin
            idle_cnt_r <= idle_cnt_r + TW'(1);
        end
    end

    assign timeout_s = (idle_cnt_r == TW'(TIMEOUT_CYC)) && (digit_count_r != CW'(0));
`else
    assign timeout_s = 1'b0;
`endif

    assign digit_s    = (key_code_r <= 4'd9);
    assign acc_calc_s = {4'b0000, acc_r} * AW'(10) + {{VAL_W{1'b0}}, key_code_r};

    // Digit accumulation and committed-value handshake; events during OUTPUT are dropped
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            en_state_r    <= EN_ENTRY;
            acc_r         <= {VAL_W{1'b0}};
            digit_count_r <= {CW{1'b0}};
            cmd_value_r   <= {VAL_W{1'b0}};
            cmd_valid_r   <= 1'b0;
        end else begin
            case (en_state_r)
                EN_ENTRY: begin
                    if (key_event_r) begin
                        if (digit_s) begin
                            if (digit_count_r < CW'(NDIGITS)) begin
                                acc_r         <= acc_calc_s[VAL_W-1:0];
                                digit_count_r <= digit_count_r + CW'(1);
                            end
                        end else if (key_code_r == KEY_STAR) begin
                            acc_r         <= {VAL_W{1'b0}};
                            digit_count_r <= {CW{1'b0}};
                        end else if ((key_code_r == KEY_HASH) && (digit_count_r != CW'(0))) begin
                            cmd_value_r <= acc_r;
                            cmd_valid_r <= 1'b1;
                            en_state_r  <= EN_OUTPUT;
                        end
                    end else if (timeout_s) begin
                        acc_r         <= {VAL_W{1'b0}};
                        digit_count_r <= {CW{1'b0}};
                    end
                end
                EN_OUTPUT: begin
                    if (cmd_ready) begin
                        cmd_valid_r   <= 1'b0;
                        acc_r         <= {VAL_W{1'b0}};
                        digit_count_r <= {CW{1'b0}};
                        en_state_r    <= EN_ENTRY;
                    end
                end
                default: en_state_r <= EN_ENTRY;
            endcase
        end
    end

    assign key_row     = key_row_r;
    assign key_event   = key_event_r;
    assign key_code    = key_code_r;
    assign digit_count = digit_count_r;
    assign cmd_value   = cmd_value_r;
    assign cmd_valid   = cmd_valid_r;

endmodule
